// File: rtl/cim_pkg.sv
// ---------------------------------------------------------------------------
// cim_pkg
// Shared definitions for the compute-in-memory array controller:
//   - state_t     : controller FSM states
//   - OP_*        : command opcodes carried on the command bus
//   - N_DEFAULT   : default array dimension (rows = columns)
//   - max_int()   : elaboration-time helper for sizing the cycle counter
// ---------------------------------------------------------------------------
package cim_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR,
    ST_COMPUTE,
    ST_RESP
  } state_t;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_COMPUTE = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cim_array_ctrl_if.sv
// ---------------------------------------------------------------------------
// cim_array_ctrl_if
// Command and result handshake bundle between the host/accelerator and the
// array controller.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op              : opcode (see cim_pkg OP_*)
//   cmd_row             : target row for WRITE
//   cmd_data            : BL data (WRITE) or input vector (COMPUTE)
//   res_valid/res_ready : result handshake
//   res_data            : captured array output
// Modports: master = host side, slave = controller side.
// ---------------------------------------------------------------------------
interface cim_array_ctrl_if #(
  parameter int N = cim_pkg::N_DEFAULT
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [$clog2(N)-1:0] cmd_row;
  logic [N-1:0]         cmd_data;
  logic                 res_valid;
  logic                 res_ready;
  logic [N-1:0]         res_data;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface

// File: rtl/cim_cycle_counter.sv
// ---------------------------------------------------------------------------
// cim_cycle_counter
// Loadable down-counter shared by the WRITE, CLEAR and COMPUTE timers.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load         : load i_load_val (takes priority over counting)
//   i_load_val     : value loaded on state entry
//   o_count        : current count
//   o_done         : high while the count is 1, i.e. the last cycle of a state
// The counter parks at 0 once expired so it never wraps while idle.
// ---------------------------------------------------------------------------
module cim_cycle_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_count,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_done  = (r_count == W'(1));

endmodule

// File: rtl/cim_array_ctrl.sv
// ---------------------------------------------------------------------------
// cim_array_ctrl
// Sequencing controller for an N x N compute-in-memory bitcell array.
// Accepts WRITE / CLEAR / COMPUTE commands, drives word lines, bit lines and
// the input vector with programmed timing, and returns the sampled array
// output over a result handshake.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : command/result handshake (slave side)
//   o_wl           : word lines
//   o_bl           : bit lines
//   o_input        : array input vector
//   o_si, o_ci     : top-row sum-in / carry-in (tied low)
//   i_arr_out      : array output bus
//   o_err          : one-cycle pulse after a reserved opcode is accepted
// All array-facing outputs are registered; cmd_ready is decoded from state.
// ---------------------------------------------------------------------------
module cim_array_ctrl
  import cim_pkg::*;
#(
  parameter int N             = N_DEFAULT,
  parameter int WR_CYCLES     = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  cim_array_ctrl_if.slave bus,
  output logic [N-1:0]  o_wl,
  output logic [N-1:0]  o_bl,
  output logic [N-1:0]  o_input,
  output logic [N-1:0]  o_si,
  output logic [N-1:0]  o_ci,
  input  logic [N-1:0]  i_arr_out,
  output logic          o_err
);

  localparam int RW    = $clog2(N);
  localparam int TOTAL = N * WR_CYCLES;
  localparam int CW    = $clog2(max_int(TOTAL, SETTLE_CYCLES) + 1);

  localparam logic [CW-1:0] CNT_WR     = CW'(WR_CYCLES);
  localparam logic [CW-1:0] CNT_CLR    = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE_CYCLES);

  state_t        r_state, w_state_next;
  logic [N-1:0]  r_wl, w_wl_next;
  logic [N-1:0]  r_bl, w_bl_next;
  logic [N-1:0]  r_input, w_input_next;
  logic          r_res_valid, w_res_valid_next;
  logic [N-1:0]  r_res_data, w_res_data_next;
  logic          r_err, w_err_next;

  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_load_val;
  logic [CW-1:0] w_count;
  logic          w_cnt_done;

  logic [N-1:0]  w_cmd_row_oh;
  logic [N-1:0]  w_clr_row_oh;
  int            w_clr_elapsed;
  logic [RW-1:0] w_clr_row;

  cim_cycle_counter #(
    .W(CW)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_count    (w_count),
    .o_done     (w_cnt_done)
  );

  // Row driven in the *next* CLEAR cycle. The counter runs TOTAL..1, so the
  // next cycle's elapsed count is TOTAL - count + 1; each row spans WR_CYCLES.
  // On the final cycle this index overflows, but it is unused there.
  assign w_clr_elapsed = TOTAL - int'(w_count) + 1;
  assign w_clr_row     = RW'(w_clr_elapsed / WR_CYCLES);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row_dec
      assign w_cmd_row_oh[gi] = (bus.cmd_row == RW'(gi));
      assign w_clr_row_oh[gi] = (w_clr_row == RW'(gi));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_wl        <= '0;
      r_bl        <= '0;
      r_input     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wl        <= w_wl_next;
      r_bl        <= w_bl_next;
      r_input     <= w_input_next;
      r_res_valid <= w_res_valid_next;
      r_res_data  <= w_res_data_next;
      r_err       <= w_err_next;
    end
  end

  // Outputs are computed one cycle ahead so that the array sees them
  // registered from the very first cycle of each state.
  always_comb begin
    w_state_next     = r_state;
    w_wl_next        = r_wl;
    w_bl_next        = r_bl;
    w_input_next     = r_input;
    w_res_valid_next = r_res_valid;
    w_res_data_next  = r_res_data;
    w_err_next       = 1'b0;
    w_cnt_load       = 1'b0;
    w_cnt_load_val   = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_WRITE: begin
              w_state_next   = ST_WRITE;
              w_wl_next      = w_cmd_row_oh;
              w_bl_next      = bus.cmd_data;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = CNT_WR;
            end
            OP_CLEAR: begin
              w_state_next   = ST_CLEAR;
              w_wl_next      = N'(1);
              w_bl_next      = '0;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = CNT_CLR;
            end
            OP_COMPUTE: begin
              w_state_next   = ST_COMPUTE;
              w_wl_next      = '1;
              w_bl_next      = '0;
              w_input_next   = bus.cmd_data;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = CNT_SETTLE;
            end
            default: begin
              // Reserved opcode: consumed, flagged, no array activity.
              w_err_next = 1'b1;
            end
          endcase
        end
      end

      ST_WRITE: begin
        if (w_cnt_done) begin
          w_state_next = ST_IDLE;
          w_wl_next    = '0;
        end
      end

      ST_CLEAR: begin
        if (w_cnt_done) begin
          w_state_next = ST_IDLE;
          w_wl_next    = '0;
        end else begin
          w_wl_next = w_clr_row_oh;
        end
      end

      ST_COMPUTE: begin
        // Sample the array exactly once, on the edge ending the settle window.
        if (w_cnt_done) begin
          w_state_next     = ST_RESP;
          w_wl_next        = '0;
          w_input_next     = '0;
          w_res_data_next  = i_arr_out;
          w_res_valid_next = 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.res_ready) begin
          w_state_next     = ST_IDLE;
          w_res_valid_next = 1'b0;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;

  assign o_wl    = r_wl;
  assign o_bl    = r_bl;
  assign o_input = r_input;
  assign o_si    = '0;
  assign o_ci    = '0;
  assign o_err   = r_err;

endmodule

// File: tb/tb_cim_array_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cim_array_ctrl
// Two controller instances: u_dut_a (WR_CYCLES=1) carries most traffic,
// u_dut_b (WR_CYCLES=2) exercises the CLEAR row walk. The array is modelled
// as returning the inverted input vector while all word lines are high.
// ---------------------------------------------------------------------------
module tb_cim_array_ctrl;
  import cim_pkg::*;

  localparam int N    = 4;
  localparam int WR_A = 1;
  localparam int WR_B = 2;
  localparam int SET  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cim_array_ctrl_if #(.N(N)) bus_a ();
  cim_array_ctrl_if #(.N(N)) bus_b ();

  logic [N-1:0] wl_a, bl_a, inp_a, si_a, ci_a, arr_a;
  logic [N-1:0] wl_b, bl_b, inp_b, si_b, ci_b, arr_b;
  logic         err_a, err_b;
  logic [N-1:0] arr_idle;

  assign arr_a = (wl_a == 4'b1111) ? ~inp_a : arr_idle;
  assign arr_b = 4'b0000;

  cim_array_ctrl #(.N(N), .WR_CYCLES(WR_A), .SETTLE_CYCLES(SET)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a),
    .o_wl(wl_a), .o_bl(bl_a), .o_input(inp_a), .o_si(si_a), .o_ci(ci_a),
    .i_arr_out(arr_a), .o_err(err_a)
  );

  cim_array_ctrl #(.N(N), .WR_CYCLES(WR_B), .SETTLE_CYCLES(SET)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b),
    .o_wl(wl_b), .o_bl(bl_b), .o_input(inp_b), .o_si(si_b), .o_ci(ci_b),
    .i_arr_out(arr_b), .o_err(err_b)
  );

  typedef struct {
    logic [1:0] op;
    logic [1:0] row;
    logic [3:0] data;
    logic [3:0] exp_wl;
    logic [3:0] exp_bl;
    logic [3:0] exp_inp;
    logic [3:0] exp_res;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present a command on bus_a and return just after its acceptance edge.
  task automatic send_a(input logic [1:0] op, input logic [1:0] row, input logic [3:0] data);
    bit done;
    done = 1'b0;
    bus_a.cmd_op    = op;
    bus_a.cmd_row   = row;
    bus_a.cmd_data  = data;
    bus_a.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus_a.cmd_ready) done = 1'b1;
      tick();
    end
    bus_a.cmd_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ready_a();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus_a.cmd_ready) done = 1'b1;
      else tick();
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    int t_first, t_second;

    vecs[0] = '{OP_WRITE,   2'd2, 4'b1011, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{OP_COMPUTE, 2'd0, 4'b0110, 4'b1111, 4'b0000, 4'b0110, 4'b1001, 1'b0};
    vecs[2] = '{OP_WRITE,   2'd0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    vecs[3] = '{OP_RSVD,    2'd1, 4'b1010, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{OP_COMPUTE, 2'd0, 4'b0011, 4'b1111, 4'b0000, 4'b0011, 4'b1100, 1'b0};
    vecs[5] = '{OP_WRITE,   2'd3, 4'b1110, 4'b1000, 4'b1110, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{OP_WRITE,   2'd1, 4'b0100, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 1'b0};

    arr_idle        = 4'b0101;
    bus_a.cmd_valid = 1'b0;
    bus_a.cmd_op    = 2'b00;
    bus_a.cmd_row   = 2'd0;
    bus_a.cmd_data  = 4'd0;
    bus_a.res_ready = 1'b1;
    bus_b.cmd_valid = 1'b0;
    bus_b.cmd_op    = 2'b00;
    bus_b.cmd_row   = 2'd0;
    bus_b.cmd_data  = 4'd0;
    bus_b.res_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(bus_a.cmd_ready), 32'd1);
    chk("rst_wl",    32'(wl_a), 32'd0);
    chk("rst_bl",    32'(bl_a), 32'd0);
    chk("rst_input", 32'(inp_a), 32'd0);
    chk("rst_rvalid", 32'(bus_a.res_valid), 32'd0);
    chk("rst_rdata", 32'(bus_a.res_data), 32'd0);
    chk("rst_err",   32'(err_a), 32'd0);
    chk("rst_si_ci", 32'({si_a, ci_a}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven single commands
    for (int v = 0; v < 7; v++) begin
      send_a(vecs[v].op, vecs[v].row, vecs[v].data);
      $display("txn %0d: op=%0d row=%0d data=%b wl=%b bl=%b input=%b err=%0d",
               v, vecs[v].op, vecs[v].row, vecs[v].data, wl_a, bl_a, inp_a, err_a);
      chk("vec_wl",    32'(wl_a),  32'(vecs[v].exp_wl));
      chk("vec_bl",    32'(bl_a),  32'(vecs[v].exp_bl));
      chk("vec_input", 32'(inp_a), 32'(vecs[v].exp_inp));
      chk("vec_err",   32'(err_a), 32'(vecs[v].exp_err));
      if (vecs[v].op == OP_WRITE) begin
        chk("wr_ready_low", 32'(bus_a.cmd_ready), 32'd0);
        tick();
        chk("wr_wl_off", 32'(wl_a), 32'd0);
        chk("wr_bl_hold", 32'(bl_a), 32'(vecs[v].exp_bl));
        chk("wr_ready_back", 32'(bus_a.cmd_ready), 32'd1);
      end else if (vecs[v].op == OP_COMPUTE) begin
        for (int i = 0; i < SET - 1; i++) tick();
        chk("cmp_not_yet", 32'(bus_a.res_valid), 32'd0);
        chk("cmp_wl_hold", 32'(wl_a), 32'hF);
        tick();
        chk("cmp_rvalid", 32'(bus_a.res_valid), 32'd1);
        chk("cmp_rdata",  32'(bus_a.res_data), 32'(vecs[v].exp_res));
        chk("cmp_wl_off", 32'({wl_a, inp_a}), 32'd0);
        tick();
        chk("cmp_resp_1cyc", 32'(bus_a.res_valid), 32'd0);
        chk("cmp_ready_back", 32'(bus_a.cmd_ready), 32'd1);
      end else begin
        chk("rsvd_ready", 32'(bus_a.cmd_ready), 32'd1);
        tick();
        chk("rsvd_err_pulse", 32'(err_a), 32'd0);
      end
    end

    // Compute under backpressure; a waiting command must not be taken
    bus_a.res_ready = 1'b0;
    send_a(OP_COMPUTE, 2'd0, 4'b0110);
    for (int i = 0; i < SET; i++) tick();
    chk("bp_rvalid", 32'(bus_a.res_valid), 32'd1);
    chk("bp_rdata",  32'(bus_a.res_data), 32'h9);
    bus_a.cmd_op    = OP_WRITE;
    bus_a.cmd_row   = 2'd0;
    bus_a.cmd_data  = 4'b0111;
    bus_a.cmd_valid = 1'b1;
    arr_idle        = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus_a.res_valid), 32'd1);
      chk("bp_hold_data",  32'(bus_a.res_data), 32'h9);
      chk("bp_no_accept",  32'({bus_a.cmd_ready, wl_a}), 32'd0);
    end
    $display("txn bp: compute 0110 held 5 cycles, res_data=%b", bus_a.res_data);
    bus_a.res_ready = 1'b1;
    tick();
    chk("bp_release", 32'(bus_a.res_valid), 32'd0);
    chk("bp_not_taken_yet", 32'(wl_a), 32'd0);
    tick();
    bus_a.cmd_valid = 1'b0;
    chk("bp_cmd_taken", 32'(wl_a), 32'h1);
    chk("bp_cmd_bl", 32'(bl_a), 32'h7);
    tick();

    // Reserved opcode followed immediately by a WRITE
    send_a(OP_RSVD, 2'd2, 4'b1111);
    bus_a.cmd_op    = OP_WRITE;
    bus_a.cmd_row   = 2'd1;
    bus_a.cmd_data  = 4'b0101;
    bus_a.cmd_valid = 1'b1;
    chk("rsvd2_err", 32'(err_a), 32'd1);
    chk("rsvd2_quiet", 32'({wl_a, inp_a}), 32'd0);
    chk("rsvd2_bl_kept", 32'(bl_a), 32'h7);
    chk("rsvd2_ready", 32'(bus_a.cmd_ready), 32'd1);
    tick();
    bus_a.cmd_valid = 1'b0;
    $display("txn rsvd+write: err=%0d wl=%b bl=%b", err_a, wl_a, bl_a);
    chk("rsvd2_err_off", 32'(err_a), 32'd0);
    chk("rsvd2_next_wl", 32'(wl_a), 32'h2);
    chk("rsvd2_next_bl", 32'(bl_a), 32'h5);
    tick();

    // Back-to-back WRITE then COMPUTE with valid held high
    t_first  = -1;
    t_second = -1;
    bus_a.cmd_op    = OP_WRITE;
    bus_a.cmd_row   = 2'd2;
    bus_a.cmd_data  = 4'b1100;
    bus_a.cmd_valid = 1'b1;
    for (int i = 0; i < 20 && t_second < 0; i++) begin
      acc = bus_a.cmd_valid && bus_a.cmd_ready;
      tick();
      if (acc) begin
        if (t_first < 0) begin
          t_first        = cyc;
          bus_a.cmd_op   = OP_COMPUTE;
          bus_a.cmd_data = 4'b1010;
        end else begin
          t_second = cyc;
        end
      end
    end
    bus_a.cmd_valid = 1'b0;
    $display("txn b2b: first accept %0d, second accept %0d", t_first, t_second);
    chk("b2b_gap", 32'(t_second - t_first), 32'(WR_A + 1));
    wait_ready_a();
    chk("b2b_result", 32'(bus_a.res_data), 32'h5);

    // CLEAR row walk on the WR_CYCLES=2 instance
    bus_b.cmd_op    = OP_WRITE;
    bus_b.cmd_row   = 2'd1;
    bus_b.cmd_data  = 4'b1111;
    bus_b.cmd_valid = 1'b1;
    tick();
    bus_b.cmd_valid = 1'b0;
    chk("clrb_pre_bl", 32'(bl_b), 32'hF);
    for (int i = 0; i < 3; i++) tick();
    bus_b.cmd_op    = OP_CLEAR;
    bus_b.cmd_valid = 1'b1;
    tick();
    bus_b.cmd_valid = 1'b0;
    for (int k = 0; k < N * WR_B; k++) begin
      logic [3:0] exp_wl;
      exp_wl = 4'b0001 << (k / WR_B);
      chk("clr_wl", 32'(wl_b), 32'(exp_wl));
      chk("clr_bl", 32'(bl_b), 32'd0);
      chk("clr_busy", 32'(bus_b.cmd_ready), 32'd0);
      tick();
    end
    $display("txn clear: done, wl=%b ready=%0d", wl_b, bus_b.cmd_ready);
    chk("clr_end_wl", 32'(wl_b), 32'd0);
    chk("clr_end_ready", 32'(bus_b.cmd_ready), 32'd1);

    // Asynchronous reset mid-COMPUTE
    send_a(OP_COMPUTE, 2'd0, 4'b1111);
    chk("rstc_wl_on", 32'(wl_a), 32'hF);
    rst_n = 1'b0;
    #2;
    chk("rstc_wl",    32'(wl_a), 32'd0);
    chk("rstc_input", 32'(inp_a), 32'd0);
    chk("rstc_rvalid", 32'(bus_a.res_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rstc_ready", 32'(bus_a.cmd_ready), 32'd1);

    // Asynchronous reset while a result is held
    bus_a.res_ready = 1'b0;
    send_a(OP_COMPUTE, 2'd0, 4'b0001);
    for (int i = 0; i < SET; i++) tick();
    chk("rstr_rvalid_on", 32'(bus_a.res_valid), 32'd1);
    chk("rstr_rdata_on", 32'(bus_a.res_data), 32'hE);
    rst_n = 1'b0;
    #2;
    chk("rstr_rvalid", 32'(bus_a.res_valid), 32'd0);
    chk("rstr_rdata",  32'(bus_a.res_data), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("rstr_ready", 32'(bus_a.cmd_ready), 32'd1);
    $display("txn reset: in-flight work dropped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
